imem_boot_loader: RTL and testbench

//   Boot-time front end that sits upstream of the 5-stage CPU core and its instruction memory.
//   - Accepts a stream of 32-bit instruction words over a valid/ready handshake.
//   - Writes the words into instruction memory starting at BOOT_ADDR.
//   - Holds the core in reset while loading, then releases it once the last word is committed.
//   - Instruction memory is built without clear-on-reset, so loaded contents survive the core reset.

---
 rtl/imem_boot_loader_if.sv | 32 +++
 rtl/imem_boot_loader.sv | 158 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Boot loader bus bundle: load request, instruction stream handshake,
// instruction memory write port and core reset/status lines.
`timescale 1ns/1ps
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-2:0] word_count;
  logic                  in_valid;
  logic [31:0]           in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [3:0]            imem_byte_enable;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, imem_byte_enable,
           cpu_reset, busy, done, error
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, imem_byte_enable,
           cpu_reset, busy, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader: streams words into imem starting at
// BOOT_ADDR while holding the core in reset, then releases the core.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned BOOT_ADDR     = 0,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic                clock,
  input  logic                reset,
  imem_boot_loader_if.slave   bus
);

  localparam int unsigned          IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned          CNT_W     = ADDR_WIDTH - 1;
  localparam logic [CNT_W-1:0]      MAX_WORDS = CNT_W'(1 << IDX_W);
  localparam logic [ADDR_WIDTH-1:0] BOOT_BASE = ADDR_WIDTH'(BOOT_ADDR);
  localparam logic [3:0]            HOLD_INIT = 4'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                state_q, state_n;
  logic [IDX_W-1:0]      index_q, index_n;
  logic [CNT_W-1:0]      count_q, count_n;
  logic [3:0]            hold_q, hold_n;

  logic                  in_ready_q, in_ready_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           wdata_q, wdata_n;
  logic                  cpu_reset_q, cpu_reset_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  error_q, error_n;

  logic                  accept;
  logic                  last_word;

  assign accept    = (state_q == S_LOAD) && bus.in_valid && in_ready_q;
  assign last_word = ({1'b0, index_q} == (count_q - CNT_W'(1)));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state, datapath and next-output decode; outputs are decoded from
  // the next state so that every output leaves a flop.
  always_comb begin
    state_n = state_q;
    index_n = index_q;
    count_n = count_q;
    hold_n  = hold_q;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word_count > MAX_WORDS) begin
            state_n = S_ERROR;
          end else if (bus.word_count == '0) begin
            state_n = S_HOLD;
            hold_n  = HOLD_INIT;
          end else begin
            state_n = S_LOAD;
            count_n = bus.word_count;
            index_n = '0;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_n    = 1'b1;
          addr_n  = BOOT_BASE + {index_q, 2'b00};
          wdata_n = bus.in_data;
          if (last_word) begin
            state_n = S_FLUSH;
          end else begin
            index_n = index_q + IDX_W'(1);
          end
        end
      end
      S_FLUSH: begin
        state_n = S_HOLD;
        hold_n  = HOLD_INIT;
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_n = S_RUN;
        end else begin
          hold_n = hold_q - 4'd1;
        end
      end
      S_RUN:   state_n = S_RUN;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_IDLE;
    endcase

    in_ready_n  = (state_n == S_LOAD);
    cpu_reset_n = (state_n != S_RUN);
    busy_n      = (state_n == S_LOAD) || (state_n == S_FLUSH) || (state_n == S_HOLD);
    done_n      = (state_n == S_RUN);
    error_n     = (state_n == S_ERROR);
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      index_q     <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      index_q     <= index_n;
      count_q     <= count_n;
      hold_q      <= hold_n;
      in_ready_q  <= in_ready_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      cpu_reset_q <= cpu_reset_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      error_q     <= error_n;
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.imem_we          = we_q;
  assign bus.imem_addr        = addr_q;
  assign bus.imem_wdata       = wdata_q;
  assign bus.imem_byte_enable = 4'b1111;
  assign bus.cpu_reset        = cpu_reset_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized loads checked against
// a write-list model (word i lands at BOOT + 4*i one cycle after its accept).
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int unsigned AW   = 12;
  localparam int unsigned BOOT = 0;
  localparam int unsigned RD   = 2;
  localparam int unsigned MAXW = 1 << (AW - 2);

  logic clock = 1'b0;
  logic reset = 1'b1;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(
    .ADDR_WIDTH   (AW),
    .BOOT_ADDR    (BOOT),
    .RELEASE_DELAY(RD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int          acc_cyc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          rel_cyc = -1;
  logic        prev_cr = 1'b1;
  logic [31:0] load_words[$];

  // Handshake observer: records the cycle index of each accepting edge
  always @(posedge clock) begin
    if (!reset && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cyc_q.push_back(cyc);
    cyc++;
  end

  // Memory-port and core-reset observer
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (prev_cr === 1'b1 && bus.cpu_reset === 1'b0) rel_cyc = cyc;
    prev_cr = bus.cpu_reset;
  end

  function automatic logic [AW-1:0] exp_addr(input int i);
    return AW'(BOOT + 4 * i);
  endfunction

  task automatic clear_log();
    acc_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rel_cyc = -1;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.word_count = 11'd4;
    bus.in_valid = 1'b1;
    bus.in_data = $urandom;
    repeat (3) @(negedge clock);
    vectors++;
    if (bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cr=%b rdy=%b we=%b busy=%b done=%b err=%b, expected 1 0 0 0 0 0",
               bus.cpu_reset, bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.error);
    end
    vectors++;
    if (bus.imem_byte_enable !== 4'b1111) begin
      miscompares++;
      $display("FAIL byte_enable: got %b expected 1111", bus.imem_byte_enable);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    clear_log();
    @(negedge clock);
    vectors++;
    if (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || wr_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got cr=%b busy=%b rdy=%b writes=%0d expected 1 0 0 0",
               bus.cpu_reset, bus.busy, bus.in_ready, wr_cyc_q.size());
    end
  endtask

  // Loads load_words with the given in_valid pattern (0: always, 1: 1,0,0 repeating,
  // 2: random) and verifies every write, its timing, and the core release.
  task automatic run_load(input int mode, input string tag);
    int n, k, budget, idx, nw;
    logic v;
    n = load_words.size();
    clear_log();
    @(negedge clock);
    bus.start = 1'b1;
    bus.word_count = n[AW-2:0];
    @(negedge clock);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s load_entry: got busy=%b rdy=%b expected 1 1", tag, bus.busy, bus.in_ready);
    end
    k = 0;
    budget = 4 * n + 20;
    while (acc_cyc_q.size() < n) begin
      if (budget == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s accept_timeout: got %0d accepts expected %0d", tag, acc_cyc_q.size(), n);
        break;
      end
      budget--;
      idx = acc_cyc_q.size();
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
      bus.in_valid = v;
      bus.in_data = v ? load_words[idx] : $urandom;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
    budget = 40;
    while (bus.done !== 1'b1 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_reset !== 1'b0 ||
        bus.error !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s run_state: got done=%b busy=%b cr=%b err=%b rdy=%b expected 1 0 0 0 0",
               tag, bus.done, bus.busy, bus.cpu_reset, bus.error, bus.in_ready);
    end
    nw = wr_cyc_q.size();
    vectors++;
    if (nw != n) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, nw, n);
    end
    for (int i = 0; i < nw && i < n; i++) begin
      vectors++;
      if (wr_addr_q[i] !== exp_addr(i)) begin
        miscompares++;
        $display("FAIL %s addr[%0d]: got %h expected %h", tag, i, wr_addr_q[i], exp_addr(i));
      end
      vectors++;
      if (wr_data_q[i] !== load_words[i]) begin
        miscompares++;
        $display("FAIL %s data[%0d]: got %h expected %h", tag, i, wr_data_q[i], load_words[i]);
      end
      if (i < acc_cyc_q.size()) begin
        vectors++;
        if (wr_cyc_q[i] != acc_cyc_q[i] + 1) begin
          miscompares++;
          $display("FAIL %s write_latency[%0d]: got cycle %0d expected %0d", tag, i, wr_cyc_q[i], acc_cyc_q[i] + 1);
        end
      end
      if (mode == 0) begin
        vectors++;
        if (wr_cyc_q[i] != wr_cyc_q[0] + i) begin
          miscompares++;
          $display("FAIL %s back_to_back[%0d]: got cycle %0d expected %0d", tag, i, wr_cyc_q[i], wr_cyc_q[0] + i);
        end
      end
    end
    if (nw > 0) begin
      vectors++;
      if (rel_cyc != wr_cyc_q[nw-1] + 1 + RD) begin
        miscompares++;
        $display("FAIL %s release_time: got cycle %0d expected %0d", tag, rel_cyc, wr_cyc_q[nw-1] + 1 + RD);
      end
    end
  endtask

  task automatic test_basic_load();
    apply_reset(2);
    load_words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
    run_load(0, "basic");
    // RUN must ignore start and stream traffic
    clear_log();
    bus.start = 1'b1;
    bus.word_count = 11'd4;
    bus.in_valid = 1'b1;
    repeat (5) begin
      bus.in_data = $urandom;
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (wr_cyc_q.size() != 0 || bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL run_ignores: got writes=%0d done=%b cr=%b rdy=%b expected 0 1 0 0",
               wr_cyc_q.size(), bus.done, bus.cpu_reset, bus.in_ready);
    end
  endtask

  task automatic test_gapped_load();
    apply_reset(2);
    load_words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
    run_load(1, "gapped");
  endtask

  task automatic test_error();
    int c;
    apply_reset(2);
    @(negedge clock);
    bus.start = 1'b1;
    bus.word_count = 11'(MAXW + 1);
    @(negedge clock);
    bus.start = 1'b0;
    vectors++;
    if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL error_entry: got err=%b cr=%b rdy=%b busy=%b done=%b expected 1 1 0 0 0",
               bus.error, bus.cpu_reset, bus.in_ready, bus.busy, bus.done);
    end
    c = 0;
    repeat (6) begin
      bus.start = c[0];
      bus.word_count = 11'd4;
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      c++;
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || wr_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL error_sticky: got err=%b cr=%b writes=%0d expected 1 1 0",
               bus.error, bus.cpu_reset, wr_cyc_q.size());
    end
  endtask

  task automatic test_zero_count();
    int c, budget;
    apply_reset(2);
    @(negedge clock);
    c = cyc;
    bus.start = 1'b1;
    bus.word_count = '0;
    @(negedge clock);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_hold: got busy=%b rdy=%b cr=%b expected 1 0 1", bus.busy, bus.in_ready, bus.cpu_reset);
    end
    budget = 20;
    while (bus.done !== 1'b1 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    @(negedge clock);
    vectors++;
    if (rel_cyc != c + RD + 1) begin
      miscompares++;
      $display("FAIL zero_release: got cycle %0d expected %0d", rel_cyc, c + RD + 1);
    end
    vectors++;
    if (wr_cyc_q.size() != 0 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_nowrite: got writes=%0d done=%b expected 0 1", wr_cyc_q.size(), bus.done);
    end
  endtask

  task automatic test_reset_abort();
    int budget;
    apply_reset(2);
    load_words.delete();
    for (int i = 0; i < 4; i++) load_words.push_back($urandom);
    @(negedge clock);
    bus.start = 1'b1;
    bus.word_count = 11'd4;
    @(negedge clock);
    bus.start = 1'b0;
    budget = 20;
    while (acc_cyc_q.size() < 2 && budget > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data = load_words[acc_cyc_q.size()];
      @(negedge clock);
      budget--;
    end
    // Third word is on the bus with valid high exactly as reset hits
    reset = 1'b1;
    bus.in_data = load_words[2];
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: got cr=%b rdy=%b busy=%b we=%b expected 1 0 0 0",
               bus.cpu_reset, bus.in_ready, bus.busy, bus.imem_we);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (wr_cyc_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_writes: got %0d writes expected 2", wr_cyc_q.size());
    end
    for (int i = 0; i < 2 && i < wr_cyc_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== exp_addr(i) || wr_data_q[i] !== load_words[i]) begin
        miscompares++;
        $display("FAIL abort_write[%0d]: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i],
                 exp_addr(i), load_words[i]);
      end
    end
    load_words.delete();
    for (int i = 0; i < 4; i++) load_words.push_back($urandom);
    run_load(0, "reload");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int it = 0; it < 6; it++) begin
      apply_reset(1 + it % 3);
      n = $urandom_range(1, 12);
      load_words.delete();
      for (int i = 0; i < n; i++) load_words.push_back($urandom);
      run_load(int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_max_count();
    apply_reset(2);
    load_words.delete();
    for (int i = 0; i < int'(MAXW); i++) load_words.push_back($urandom);
    run_load(0, "max_count");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_error();
    test_zero_count();
    test_reset_abort();
    test_back_to_back();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
